// File: rtl/xlr8_twi_pkg.sv
// Shared definitions for the TWI (I2C) target: FSM states and the default address.
`timescale 1ns/1ps
package xlr8_twi_pkg;

    localparam logic [6:0]  DEFAULT_DEV_ADDR = 7'h50;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned CNT_W            = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK
    } twi_state_e;

endpackage

// File: rtl/xlr8_sync2.sv
// Two-flop synchronizer for an asynchronous pin; resets to the idle-high bus level.
`timescale 1ns/1ps
module xlr8_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/xlr8_twi_target.sv
// I2C target with a byte-pointer register file: write sets pointer then data,
// read streams bytes from the pointer; pointer auto-increments and wraps.
`timescale 1ns/1ps
module xlr8_twi_target
    import xlr8_twi_pkg::*;
#(
    parameter logic [6:0]     DEV_ADDR  = DEFAULT_DEV_ADDR,
    parameter int unsigned    MEM_DEPTH = 16,
    localparam int unsigned   AW        = $clog2(MEM_DEPTH)
) (
    input  logic              Clock,
    input  logic              RESET_N,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_stb,
    input  logic [AW-1:0]     rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic scl_s, sda_s, scl_h, sda_h;

    xlr8_sync2 u_sync_scl (.clk(Clock), .rst_n(RESET_N), .d(scl_i), .q(scl_s));
    xlr8_sync2 u_sync_sda (.clk(Clock), .rst_n(RESET_N), .d(sda_i), .q(sda_s));

    always_ff @(posedge Clock or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_h <= 1'b1;
            sda_h <= 1'b1;
        end else begin
            scl_h <= scl_s;
            sda_h <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s & ~scl_h;
    assign scl_fall  = ~scl_s &  scl_h;
    assign start_det =  scl_s &  scl_h &  sda_h & ~sda_s;
    assign stop_det  =  scl_s &  scl_h & ~sda_h &  sda_s;

    twi_state_e        state, state_n;
    logic [CNT_W-1:0]  bit_cnt, cnt_n;
    logic [6:0]        shift, shift_n;
    logic [AW-1:0]     ptr, ptr_n;
    logic              oe_n, busy_n, rw, rw_n, mem_we;
    logic [AW-1:0]     wr_idx;
    logic [BYTE_W-1:0] wr_data;
    logic [BYTE_W-1:0] mem [MEM_DEPTH];
    logic [BYTE_W-1:0] byte_in, rd_byte;

    assign byte_in = {shift, sda_s};
    assign rd_byte = mem[ptr];
    assign rd_data = mem[rd_addr];

    always_ff @(posedge Clock or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            rw      <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            sda_oe  <= oe_n;
            busy    <= busy_n;
            rw      <= rw_n;
            wr_stb  <= mem_we;
            if (mem_we) begin
                wr_idx  <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    // Commit lags wr_stb by one cycle so a coinciding local read still sees the old byte.
    always_ff @(posedge Clock or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (wr_stb) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // In ACK states sda_oe doubles as the phase flag: first SCL fall drives, second releases.
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift;
        ptr_n   = ptr;
        oe_n    = sda_oe;
        busy_n  = busy;
        rw_n    = rw;
        mem_we  = 1'b0;

        if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    shift_n = byte_in[6:0];
                    cnt_n   = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_W'(7)) begin
                        cnt_n = '0;
                        rw_n  = sda_s;
                        if (shift == DEV_ADDR) begin
                            state_n = ADDR_ACK;
                            busy_n  = 1'b1;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_n = 1'b1;
                    end else if (rw) begin
                        state_n = RDATA;
                        shift_n = rd_byte[6:0];
                        oe_n    = ~rd_byte[7];
                        cnt_n   = '0;
                    end else begin
                        state_n = PTR;
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                    end
                end
                PTR: if (scl_rise) begin
                    shift_n = byte_in[6:0];
                    cnt_n   = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_W'(7)) begin
                        ptr_n   = byte_in[AW-1:0];
                        cnt_n   = '0;
                        state_n = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_n = 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        state_n = WDATA;
                        cnt_n   = '0;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_n = byte_in[6:0];
                    cnt_n   = CNT_W'(bit_cnt + 1'b1);
                    if (bit_cnt == CNT_W'(7)) begin
                        mem_we  = 1'b1;
                        ptr_n   = AW'(ptr + 1'b1);
                        cnt_n   = '0;
                        state_n = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_n = CNT_W'(bit_cnt + 1'b1);
                    end else if (scl_fall) begin
                        if (bit_cnt == CNT_W'(8)) begin
                            oe_n    = 1'b0;
                            ptr_n   = AW'(ptr + 1'b1);
                            cnt_n   = '0;
                            state_n = RACK;
                        end else begin
                            oe_n    = ~shift[6];
                            shift_n = {shift[5:0], 1'b0};
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) cnt_n = CNT_W'(1);
                        else        state_n = IDLE;
                    end else if (scl_fall && bit_cnt == CNT_W'(1)) begin
                        state_n = RDATA;
                        shift_n = rd_byte[6:0];
                        oe_n    = ~rd_byte[7];
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xlr8_twi_target.sv
// Bus-level bench for xlr8_twi_target: bit-banged master, reference register file and scoreboards.
`timescale 1ns/1ps
module tb_xlr8_twi_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n, scl, msda, sda_bus, sda_oe, busy, wr_stb;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;

    always #5 clk = ~clk;
    assign sda_bus = msda & ~sda_oe;

    xlr8_twi_target #(.DEV_ADDR(7'h50), .MEM_DEPTH(16)) dut (
        .Clock(clk), .RESET_N(rst_n), .scl_i(scl), .sda_i(sda_bus),
        .sda_oe(sda_oe), .busy(busy), .wr_stb(wr_stb),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    typedef struct { logic [3:0] idx; logic [7:0] old_v; logic [7:0] new_v; } wr_t;

    wr_t        wr_q [$];
    logic       ack_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] model [16];
    logic [3:0] mptr;
    int         tests = 0, fails = 0, wr_cnt = 0;
    logic       oe_seen, busy_seen, chk_new;
    logic [7:0] new_val;

    // One clock step; also watches wr_stb against the write scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk); #1;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (chk_new) begin
            tests++;
            if (rd_data !== new_val) begin
                fails++; $display("FAIL wr_new idx=%0d got %h want %h", rd_addr, rd_data, new_val);
            end
            chk_new = 1'b0;
        end
        if (wr_stb) begin
            wr_cnt++;
            tests++;
            if (wr_q.size() == 0) begin
                fails++; $display("FAIL wr_unexpected got wr_stb want none");
            end else begin
                e = wr_q.pop_front();
                if (rd_data !== e.old_v) begin
                    fails++; $display("FAIL wr_old idx=%0d got %h want %h", e.idx, rd_data, e.old_v);
                end
                new_val = e.new_v;
                chk_new = 1'b1;
            end
        end
        if (!chk_new && wr_q.size() != 0) rd_addr = wr_q[0].idx;
    endtask

    task automatic wait_q(); repeat (Q) tick(); endtask

    task automatic bus_start();
        msda = 1'b1; wait_q(); scl = 1'b1; wait_q(); msda = 1'b0; wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        msda = 1'b0; wait_q(); scl = 1'b1; wait_q(); msda = 1'b1; wait_q();
    endtask

    task automatic scl_fall(output int lat);
        logic prev;
        prev = sda_oe; scl = 1'b0; lat = 0;
        for (int k = 1; k <= Q; k++) begin
            tick();
            if (lat == 0 && sda_oe !== prev) lat = k;
        end
    endtask

    task automatic send_bit(input logic b, output logic seen, output int lat);
        msda = b; wait_q(); scl = 1'b1; wait_q(); seen = sda_bus; wait_q(); scl_fall(lat);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic chk_rel);
        logic seen, exp;
        int   lat;
        ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], seen, lat);
            if (i == 0 && exp_ack) begin
                tests++;
                if (lat !== 3) begin fails++; $display("FAIL ack_on_lat byte=%h got %0d want 3", b, lat); end
            end
        end
        send_bit(1'b1, seen, lat);
        exp = ack_q.pop_front();
        tests++;
        if (seen !== ~exp) begin fails++; $display("FAIL ack byte=%h got sda=%b want %b", b, seen, ~exp); end
        if (exp && chk_rel) begin
            tests++;
            if (lat !== 3) begin fails++; $display("FAIL ack_off_lat byte=%h got %0d want 3", b, lat); end
        end
    endtask

    task automatic recv_byte(input logic master_ack);
        logic [7:0] d, exp;
        logic       seen;
        int         lat;
        for (int i = 7; i >= 0; i--) begin send_bit(1'b1, seen, lat); d[i] = seen; end
        exp = rd_q.pop_front();
        tests++;
        if (d !== exp) begin fails++; $display("FAIL rd_byte got %h want %h", d, exp); end
        send_bit(~master_ack, seen, lat);
    endtask

    task automatic push_write(input logic [7:0] d);
        wr_t e;
        e.idx = mptr; e.old_v = model[mptr]; e.new_v = d;
        model[mptr] = d; mptr = mptr + 4'd1;
        wr_q.push_back(e);
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            tests++;
            if (rd_data !== model[i]) begin
                fails++; $display("FAIL %s mem[%0d] got %h want %h", name, i, rd_data, model[i]);
            end
        end
    endtask

    task automatic check_idle(input string name);
        repeat (4) tick();
        tests++;
        if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            fails++; $display("FAIL %s_idle got busy=%b oe=%b want 0 0", name, busy, sda_oe);
        end
    endtask

    task automatic write_txn(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1, input int n);
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b1);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_match got %b want 1", busy); end
        send_byte(p, 1'b1, 1'b1);
        mptr = p[3:0];
        push_write(d0); send_byte(d0, 1'b1, 1'b1);
        if (n > 1) begin push_write(d1); send_byte(d1, 1'b1, 1'b1); end
        bus_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scl = 1'b1; msda = 1'b1;
        repeat (3) tick();
        tests++;
        if (sda_oe !== 1'b0 || busy !== 1'b0 || wr_stb !== 1'b0) begin
            fails++; $display("FAIL reset_out got oe=%b busy=%b stb=%b want 0 0 0", sda_oe, busy, wr_stb);
        end
        check_mem("reset");
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_write();
        int c0 = wr_cnt;
        write_txn(8'h03, 8'h5A, 8'hC3, 2);
        check_idle("write");
        tests++;
        if (wr_cnt - c0 !== 2) begin fails++; $display("FAIL write_stb got %0d want 2", wr_cnt - c0); end
        check_mem("write");
    endtask

    task automatic test_read();
        rd_q.push_back(model[3]); rd_q.push_back(model[4]);
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b1);
        send_byte(8'h03, 1'b1, 1'b1);
        bus_start();
        send_byte(8'hA1, 1'b1, 1'b0);
        recv_byte(1'b1);
        recv_byte(1'b0);
        bus_stop();
        check_idle("read");
    endtask

    task automatic test_mismatch();
        int c0 = wr_cnt;
        oe_seen = 1'b0; busy_seen = 1'b0;
        bus_start();
        send_byte(8'hA2, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0);
        bus_stop();
        repeat (4) tick();
        tests++;
        if (oe_seen !== 1'b0 || busy_seen !== 1'b0 || wr_cnt != c0) begin
            fails++; $display("FAIL mismatch got oe=%b busy=%b wr=%0d want 0 0 0", oe_seen, busy_seen, wr_cnt - c0);
        end
        check_mem("mismatch");
    endtask

    task automatic test_wrap();
        write_txn(8'h0F, 8'h11, 8'h22, 2);
        check_idle("wrap");
        check_mem("wrap");
    endtask

    task automatic test_stop_mid();
        logic seen;
        int   lat, c0;
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b1);
        send_byte(8'h05, 1'b1, 1'b1);
        c0 = wr_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1, seen, lat);
        bus_stop();
        check_idle("stop_mid");
        tests++;
        if (wr_cnt != c0) begin fails++; $display("FAIL stop_mid_stb got %0d want 0", wr_cnt - c0); end
        check_mem("stop_mid");
    endtask

    task automatic test_reset_mid();
        logic       seen;
        logic [3:0] hi;
        int         lat;
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b1);
        send_byte(8'h04, 1'b1, 1'b1);
        bus_start();
        send_byte(8'hA1, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) begin send_bit(1'b1, seen, lat); hi[i] = seen; end
        tests++;
        if (hi !== model[4][7:4] || sda_oe !== ~model[4][3]) begin
            fails++; $display("FAIL rmid_bits got %b oe=%b want %b oe=%b", hi, sda_oe, model[4][7:4], ~model[4][3]);
        end
        rst_n = 1'b0; #1;
        tests++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rmid_async got oe=%b busy=%b want 0 0", sda_oe, busy);
        end
        scl = 1'b1; msda = 1'b1;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        check_mem("rmid_clear");
        write_txn(8'h07, 8'h99, 8'h00, 1);
        check_idle("rmid_write");
        check_mem("rmid_write");
        rd_q.push_back(8'h99);
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b1);
        send_byte(8'h07, 1'b1, 1'b1);
        bus_start();
        send_byte(8'hA1, 1'b1, 1'b0);
        recv_byte(1'b0);
        bus_stop();
        check_idle("rmid_read");
    endtask

    initial begin
        oe_seen = 1'b0; busy_seen = 1'b0; chk_new = 1'b0; new_val = 8'h00;
        rd_addr = 4'h0; mptr = 4'h0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_stop_mid();
        test_reset_mid();
        tests++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || ack_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_left got wr=%0d rd=%0d ack=%0d want 0 0 0", wr_q.size(), rd_q.size(), ack_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
